booth_seq_ctrl: RTL
===================

BOOTH_SEQ_CTRL -- requirements
Module: booth_seq_ctrl

Interface
REQ-001 Parameters (name, default, meaning): DEPTH, 4, operand FIFO entries, power of two, at least 2; TIMEOUT, 8, maximum WAIT cycles before a job is flagged as an error.
REQ-002 Port: clk  in  1  single clock; all flops on its rising edge.
REQ-003 Port: resetn  in  1  asynchronous active-low reset.
REQ-004 Ports: in_valid in 1, in_ready out 1, in_m in 4, in_a in 4: operand pair (signed 2's complement), valid/ready handshake.
REQ-005 Ports: out_valid out 1, out_ready in 1, out_product out 8, out_err out 1: result, valid/ready handshake.
REQ-006 Ports: mult_m out 4, mult_a out 4, mult_resetn out 1: operands and restart to the downstream 4x4 Booth multiplier.
REQ-007 Ports: mult_valid in 1, mult_product in 8: multiplier completion flag and signed product.
REQ-008 Ports: busy out 1, high when the FSM is not IDLE or the FIFO is non-empty; chk_err out 1, see REQ-021/022.

Function
REQ-009 Input transfer when in_valid && in_ready; in_ready = !fifo_full, a registered-state function with no combinational path from in_valid.
REQ-010 FIFO: DEPTH entries, wrapping pointers, occupancy count 0..DEPTH; push and pop in the same cycle leaves the count unchanged; push is blocked when full; pop occurs only from IDLE when non-empty.
REQ-011 FSM states: IDLE, LAUNCH, WAIT, OUT.
REQ-012 IDLE: mult_resetn=0; when the FIFO is non-empty, pop the head into mult_m/mult_a registers and go to LAUNCH.
REQ-013 LAUNCH: exactly 1 cycle with mult_resetn=0 and operands stable; then go to WAIT.
REQ-014 WAIT: mult_resetn=1 (registered output, glitch-free); mult_m/mult_a held constant; wait counter increments every cycle.
REQ-015 WAIT, mult_valid=1: capture mult_product into out_product, out_err=0, go to OUT.
REQ-016 WAIT, counter reaches TIMEOUT without mult_valid: out_product=8'h00, out_err=1, go to OUT; if mult_valid is high on the timeout cycle, REQ-015 wins.
REQ-017 OUT: out_valid=1; out_product and out_err stable until out_valid && out_ready; then go to IDLE (mult_resetn returns to 0); out_valid is 0 in all other states.
REQ-018 mult_valid is ignored outside WAIT.
REQ-019 Minimum turnaround: pop edge to out_valid = 2 + (number of WAIT cycles until mult_valid) cycles; at most one job is in the multiplier.

Reset
REQ-020 On resetn=0, asynchronously: state=IDLE, FIFO empty, pointers/count=0, in_ready=1, out_valid=0, out_product=0, out_err=0, mult_m=0, mult_a=0, mult_resetn=0, busy=0, chk_err=0; reset mid-job discards all buffered and in-flight operands without emitting a result.

Configuration
REQ-021 With macro BOOTH_SEQ_CHECK_EN defined: on each REQ-015 capture, compare mult_product to the signed 8-bit product of the registered mult_m*mult_a; on mismatch set chk_err=1, sticky until reset.
REQ-022 Without BOOTH_SEQ_CHECK_EN: chk_err is tied to 0, no checker logic is present, and all other behaviour is identical.

Verification
REQ-023 Push m=3, a=-2 (4'hE), with the model asserting mult_valid 4 cycles after mult_resetn rises -> out_product=8'hFA, out_err=0, mult_resetn low exactly 1 cycle before WAIT.
REQ-024 Push m=-8, a=-8, then m=7, a=7, with out_ready held 0 for 5 cycles -> 8'h40 held stable until accepted, then 8'h31; results in push order.
REQ-025 Push 6 pairs back-to-back with out_ready=0 -> in_ready drops after the FIFO holds DEPTH=4 entries plus 1 in flight; no pair is lost or duplicated.
REQ-026 Model never asserts mult_valid -> out_valid with out_err=1 and out_product=8'h00 after TIMEOUT=8 WAIT cycles; the next job proceeds normally.
REQ-027 Assert resetn low during WAIT with 2 pairs queued -> all outputs at reset values, FIFO empty, and no out_valid after release.
REQ-028 BOOTH_SEQ_CHECK_EN defined, model returns 8'h00 for m=2, a=3 -> chk_err=1 and stays 1 through later correct jobs.

Source files
------------

// File: rtl/booth_seq_ctrl.sv
// Sequencer that queues signed 4-bit operand pairs and drives an external 4x4 Booth multiplier.
// Optional product checker is enabled by defining BOOTH_SEQ_CHECK_EN.
module booth_seq_ctrl #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_m,
    input  logic [3:0] in_a,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_product,
    output logic       out_err,
    output logic [3:0] mult_m,
    output logic [3:0] mult_a,
    output logic       mult_resetn,
    input  logic       mult_valid,
    input  logic [7:0] mult_product,
    output logic       busy,
    output logic       chk_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_OUT
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic [7:0]     r_mem [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;
    logic [TW-1:0]  r_wcnt;
    logic [3:0]     r_mult_m;
    logic [3:0]     r_mult_a;
    logic           r_mult_resetn;
    logic [7:0]     r_out_product;
    logic           r_out_err;

    logic           w_full;
    logic           w_push;
    logic           w_pop;
    logic           w_capture;
    logic           w_timeout;
    logic [7:0]     w_head;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_push    = in_valid && !w_full;
    assign w_pop     = (r_state == S_IDLE) && (r_count != '0);
    assign w_head    = r_mem[r_rptr];
    assign w_capture = (r_state == S_WAIT) && mult_valid;
    assign w_timeout = (r_state == S_WAIT) && !mult_valid && (r_wcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {in_m, in_a};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_next = S_LAUNCH;
                end
            end
            S_LAUNCH: w_next = S_WAIT;
            S_WAIT: begin
                if (w_capture || w_timeout) begin
                    w_next = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_wcnt        <= '0;
            r_mult_m      <= '0;
            r_mult_a      <= '0;
            r_mult_resetn <= 1'b0;
            r_out_product <= '0;
            r_out_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wcnt  <= (r_state == S_WAIT) ? r_wcnt + 1'b1 : '0;
            // Multiplier stays released while its result is parked in OUT.
            r_mult_resetn <= (w_next == S_WAIT) || (w_next == S_OUT);
            if (w_pop) begin
                r_mult_m <= w_head[7:4];
                r_mult_a <= w_head[3:0];
            end
            if (w_capture) begin
                r_out_product <= mult_product;
                r_out_err     <= 1'b0;
            end else if (w_timeout) begin
                r_out_product <= '0;
                r_out_err     <= 1'b1;
            end
        end
    end

`ifdef BOOTH_SEQ_CHECK_EN
    logic signed [7:0] w_m_ext;
    logic signed [7:0] w_a_ext;
    logic signed [7:0] w_expect;
    logic              r_chk_err;

    assign w_m_ext  = {{4{r_mult_m[3]}}, r_mult_m};
    assign w_a_ext  = {{4{r_mult_a[3]}}, r_mult_a};
    assign w_expect = w_m_ext * w_a_ext;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_chk_err <= 1'b0;
        end else if (w_capture && (mult_product != w_expect)) begin
            r_chk_err <= 1'b1;
        end
    end

    assign chk_err = r_chk_err;
`else
    assign chk_err = 1'b0;
`endif

    assign in_ready    = !w_full;
    assign out_valid   = (r_state == S_OUT);
    assign out_product = r_out_product;
    assign out_err     = r_out_err;
    assign mult_m      = r_mult_m;
    assign mult_a      = r_mult_a;
    assign mult_resetn = r_mult_resetn;
    assign busy        = (r_state != S_IDLE) || (r_count != '0);

endmodule
